nexys_starship_hazard_gen: RTL and testbench

Hazard scheduler for Nexys Starship: decides when a shield station breaks and what hex repair code it demands. Sits directly upstream of the four station controllers (left/right/up/down). Drives their one-hot `*_random` break strobes and the shared `random_hex` code, and shortens the interval between hazards as the game progresses. Runs on `timer_clk`. Every output is held for a full `timer_clk` period, so the `Clk`-domain station FSMs sample it reliably.

---
 rtl/nexys_starship_pkg.sv | 33 +++
 rtl/nexys_starship_lfsr16.sv | 27 ++
 rtl/nexys_starship_hazard_gen.sv | 156 +++++++++++++++
 tb/tb_nexys_starship_hazard_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship hazard scheduler and the station
// controllers it drives.
`timescale 1ns/1ps
package nexys_starship_pkg;

    typedef enum logic [1:0] {
        HG_IDLE  = 2'd0,
        HG_COUNT = 2'd1,
        HG_FIRE  = 2'd2
    } hg_state_t;

    localparam logic [15:0] LFSR_TAPS             = 16'hB400;
    localparam logic [15:0] DEF_LFSR_SEED         = 16'hACE1;
    localparam logic [7:0]  DEF_BASE_INTERVAL     = 8'd40;
    localparam logic [7:0]  DEF_MIN_INTERVAL      = 8'd8;
    localparam logic [7:0]  DEF_RAMP_STEP         = 8'd4;
    localparam int          DEF_RAMP_EVENTS       = 4;

    // Station bit positions within station_random / broken_status.
    localparam int STATION_LR = 0;
    localparam int STATION_RR = 1;
    localparam int STATION_UR = 2;
    localparam int STATION_DR = 3;

    // Countdown load: interval plus 0..7 cycles of jitter, clamped to 8 bits.
    function automatic logic [7:0] countdown_load(input logic [7:0] interval,
                                                  input logic [2:0] jitter);
        logic [8:0] sum;
        sum = {1'b0, interval} + {6'b0, jitter};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// 16-bit Galois LFSR; reload has priority over advance.
`timescale 1ns/1ps
module nexys_starship_lfsr16
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] RESET_VALUE = DEF_LFSR_SEED
) (
    input  logic        timer_clk,
    input  logic        Reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    // Shift right, folding the taps in whenever a one falls out of bit 0.
    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            state <= RESET_VALUE;
        end else if (load) begin
            state <= seed;
        end else if (enable) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/nexys_starship_hazard_gen.sv
// Hazard scheduler: times station breakdowns, picks the struck station and its
// repair code, and ramps difficulty as hazards accumulate.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// HG_IDLE  | game not running; everything held at its starting value
// HG_COUNT | counting down to the next hazard
// HG_FIRE  | one cycle: strike an unbroken station (if any) and reload
`timescale 1ns/1ps
module nexys_starship_hazard_gen
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED     = DEF_LFSR_SEED,
    parameter logic [7:0]  BASE_INTERVAL = DEF_BASE_INTERVAL,
    parameter logic [7:0]  MIN_INTERVAL  = DEF_MIN_INTERVAL,
    parameter logic [7:0]  RAMP_STEP     = DEF_RAMP_STEP,
    parameter int          RAMP_EVENTS   = DEF_RAMP_EVENTS
) (
    input  logic       timer_clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic [3:0] broken_status,
    output logic [3:0] station_random,
    output logic [3:0] random_hex,
    output logic [2:0] hazard_level,
    output logic       q_HG_Idle,
    output logic       q_HG_Count,
    output logic       q_HG_Fire
);

    hg_state_t   state_q, state_d;
    logic [7:0]  countdown_q;
    logic [7:0]  interval_q;
    logic [7:0]  interval_next;
    logic [7:0]  events_q;
    logic [7:0]  events_inc;
    logic [2:0]  level_q;
    logic [3:0]  hex_q;
    logic [3:0]  fire_hex;
    logic [15:0] lfsr;
    logic        lfsr_unused;
    logic        fire_ok;
    logic        ramp;
    logic [1:0]  target;
    logic [1:0]  idx;
    logic [8:0]  ramp_floor;

    nexys_starship_lfsr16 #(
        .RESET_VALUE(LFSR_SEED)
    ) u_lfsr (
        .timer_clk(timer_clk),
        .Reset    (Reset),
        .enable   (state_q != HG_IDLE),
        .load     (state_d == HG_IDLE),
        .seed     (LFSR_SEED),
        .state    (lfsr)
    );

    // Only the candidate, code and jitter fields of the LFSR are consumed.
    assign lfsr_unused = ^{lfsr[15:11], lfsr[3:2]};

    // Next-state decode plus station selection for the fire cycle.
    always_comb begin
        state_d = state_q;
        fire_ok = 1'b0;
        target  = lfsr[1:0];
        idx     = lfsr[1:0];
        // Walk downward so the nearest unbroken station above the candidate wins.
        for (int k = 3; k >= 0; k--) begin
            idx = lfsr[1:0] + 2'(k);
            if (!broken_status[idx]) begin
                target = idx;
            end
        end
        unique case (state_q)
            HG_IDLE: begin
                if (play_flag && !gameover_ctrl) state_d = HG_COUNT;
            end
            HG_COUNT: begin
                if (gameover_ctrl)             state_d = HG_IDLE;
                else if (countdown_q == 8'd0)  state_d = HG_FIRE;
            end
            HG_FIRE: begin
                if (gameover_ctrl) begin
                    state_d = HG_IDLE;
                end else begin
                    state_d = HG_COUNT;
                    fire_ok = ~&broken_status;
                end
            end
            default: state_d = HG_IDLE;
        endcase
    end

    // Repair code and difficulty ramp derived from the current fire decision.
    always_comb begin
        fire_hex      = (lfsr[7:4] == 4'h0) ? 4'h1 : lfsr[7:4];
        events_inc    = events_q + 8'd1;
        ramp          = fire_ok && (events_inc == 8'(RAMP_EVENTS));
        ramp_floor    = {1'b0, MIN_INTERVAL} + {1'b0, RAMP_STEP};
        interval_next = interval_q;
        if (ramp) begin
            interval_next = ({1'b0, interval_q} >= ramp_floor) ? (interval_q - RAMP_STEP)
                                                               : MIN_INTERVAL;
        end
    end

    // State register.
    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) state_q <= HG_IDLE;
        else       state_q <= state_d;
    end

    // Countdown, interval, event count, level and held repair code.
    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            countdown_q <= 8'd0;
            interval_q  <= BASE_INTERVAL;
            events_q    <= 8'd0;
            level_q     <= 3'd0;
            hex_q       <= 4'h0;
        end else if (state_d == HG_IDLE) begin
            countdown_q <= 8'd0;
            interval_q  <= BASE_INTERVAL;
            events_q    <= 8'd0;
            level_q     <= 3'd0;
            hex_q       <= 4'h0;
        end else begin
            if (state_d == HG_COUNT && state_q != HG_COUNT) begin
                countdown_q <= countdown_load(interval_next, lfsr[10:8]);
            end else if (state_q == HG_COUNT && countdown_q != 8'd0) begin
                countdown_q <= countdown_q - 8'd1;
            end
            if (fire_ok) begin
                hex_q <= fire_hex;
                if (ramp) begin
                    events_q   <= 8'd0;
                    interval_q <= interval_next;
                    level_q    <= (level_q == 3'd7) ? 3'd7 : level_q + 3'd1;
                end else begin
                    events_q   <= events_inc;
                end
            end
        end
    end

    // Strobe and the new code appear together during the fire cycle itself.
    assign station_random = fire_ok ? (4'b0001 << target) : 4'b0000;
    assign random_hex     = fire_ok ? fire_hex : hex_q;
    assign hazard_level   = level_q;
    assign q_HG_Idle      = (state_q == HG_IDLE);
    assign q_HG_Count     = (state_q == HG_COUNT);
    assign q_HG_Fire      = (state_q == HG_FIRE);

endmodule

// File: tb/tb_nexys_starship_hazard_gen.sv
// Bench for the hazard scheduler: IDLE-phase vector table, hand-built corner
// sequences, and randomized breakage checked cycle by cycle against a model.
`timescale 1ns/1ps
module tb_nexys_starship_hazard_gen;

    localparam int M_IDLE  = 0;
    localparam int M_COUNT = 1;
    localparam int M_FIRE  = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       timer_clk = 1'b0;
    logic       Reset;
    logic       play_flag;
    logic       gameover_ctrl;
    logic [3:0] broken_status;
    logic [3:0] station_random;
    logic [3:0] random_hex;
    logic [2:0] hazard_level;
    logic       q_HG_Idle, q_HG_Count, q_HG_Fire;

    nexys_starship_hazard_gen dut (
        .timer_clk     (timer_clk),
        .Reset         (Reset),
        .play_flag     (play_flag),
        .gameover_ctrl (gameover_ctrl),
        .broken_status (broken_status),
        .station_random(station_random),
        .random_hex    (random_hex),
        .hazard_level  (hazard_level),
        .q_HG_Idle     (q_HG_Idle),
        .q_HG_Count    (q_HG_Count),
        .q_HG_Fire     (q_HG_Fire)
    );

    always #5 timer_clk = ~timer_clk;

    int checks = 0;
    int errors = 0;

    // Game model, expressed directly in terms of the game rules.
    int          m_state, m_cd, m_interval, m_events, m_level, m_hex, g_jit;
    logic [15:0] m_lfsr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int load_of(input int interval, input logic [15:0] l);
        int s;
        s = interval + int'(l[10:8]);
        return (s > 255) ? 255 : s;
    endfunction

    task automatic model_idle();
        m_state = M_IDLE; m_cd = 0; m_interval = 40; m_events = 0;
        m_level = 0; m_hex = 0; m_lfsr = SEED;
    endtask

    // One clock: apply inputs, compare outputs, advance the model and DUT.
    task automatic step(input logic play, input logic go, input logic [3:0] brk,
                        output int fired);
        int tgt, exp_sr, exp_hex, exp_q, c, h;
        logic [15:0] old;
        play_flag = play; gameover_ctrl = go; broken_status = brk;
        #1;
        tgt = -1;
        if (m_state == M_FIRE && !go) begin
            c = int'(m_lfsr[1:0]);
            for (int k = 0; k < 4; k++)
                if (tgt < 0 && !brk[(c + k) % 4]) tgt = (c + k) % 4;
        end
        h = (m_lfsr[7:4] == 4'h0) ? 1 : int'(m_lfsr[7:4]);
        exp_sr  = (tgt >= 0) ? (1 << tgt) : 0;
        exp_hex = (tgt >= 0) ? h : m_hex;
        exp_q   = (m_state == M_IDLE) ? 4 : (m_state == M_COUNT) ? 2 : 1;
        chk("station_random", int'(station_random), exp_sr);
        chk("random_hex", int'(random_hex), exp_hex);
        chk("hazard_level", int'(hazard_level), m_level);
        chk("state_onehot", int'({q_HG_Idle, q_HG_Count, q_HG_Fire}), exp_q);
        fired = tgt;
        old = m_lfsr;
        if (m_state == M_IDLE) begin
            if (play && !go) begin
                m_state = M_COUNT;
                m_cd = load_of(m_interval, m_lfsr);
            end
        end else if (go) begin
            model_idle();
        end else if (m_state == M_COUNT) begin
            m_lfsr = lfsr_step(old);
            if (m_cd == 0) m_state = M_FIRE;
            else m_cd--;
        end else begin
            g_jit = int'(old[10:8]);
            if (tgt >= 0) begin
                m_hex = h;
                m_events++;
                if (m_events == 4) begin
                    m_events = 0;
                    m_interval = (m_interval - 4 < 8) ? 8 : m_interval - 4;
                    m_level = (m_level + 1 > 7) ? 7 : m_level + 1;
                end
            end
            m_cd = load_of(m_interval, old);
            m_lfsr = lfsr_step(old);
            m_state = M_COUNT;
        end
        @(posedge timer_clk);
        @(negedge timer_clk);
    endtask

    task automatic run_to_fire(input string name);
        int f, b;
        b = 0;
        while (m_state != M_FIRE && b < 400) begin
            step(1'b0, 1'b0, 4'h0, f);
            b++;
        end
        if (m_state != M_FIRE) chk({name, "_timeout"}, 0, 1);
    endtask

    // From IDLE: start a game and measure the COUNT cycles before the first strobe.
    task automatic first_fire(input string name);
        int f, n, b;
        step(1'b1, 1'b0, 4'h0, f);
        n = 0; b = 0;
        while (station_random == 4'h0 && b < 300) begin
            if (q_HG_Count) n++;
            step(1'b0, 1'b0, 4'h0, f);
            b++;
        end
        chk({name, "_spacing"}, n, 45);
        chk({name, "_onehot"}, $countones(station_random), 1);
        chk({name, "_hex_nonzero"}, int'(random_hex != 4'h0), 1);
        step(1'b0, 1'b0, 4'h0, f);
        chk({name, "_width"}, int'(station_random), 0);
    endtask

    typedef struct {
        logic       play;
        logic       go;
        logic [3:0] brk;
        logic       exp_idle;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int f, c, fires, cyc, spacing, jit;
        logic [3:0] brk;
        logic was_count;

        tbl[0] = '{1'b0, 1'b0, 4'h0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 4'h0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 4'hF, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 4'h0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 4'h5, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 4'h0, 1'b1};

        Reset = 1'b1; play_flag = 1'b0; gameover_ctrl = 1'b0; broken_status = 4'h0;
        g_jit = 0;
        model_idle();
        @(negedge timer_clk);
        @(negedge timer_clk);
        Reset = 1'b0;
        #1;
        chk("reset_station_random", int'(station_random), 0);
        chk("reset_random_hex", int'(random_hex), 0);
        chk("reset_level", int'(hazard_level), 0);
        chk("reset_idle", int'(q_HG_Idle), 1);
        @(negedge timer_clk);

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].play, tbl[i].go, tbl[i].brk, f);
            chk($sformatf("tbl%0d_idle", i), int'(q_HG_Idle), int'(tbl[i].exp_idle));
        end

        first_fire("basic_fire");

        run_to_fire("rotate");
        c = int'(m_lfsr[1:0]);
        brk = 4'h0;
        brk[c] = 1'b1;
        brk[(c + 1) % 4] = 1'b1;
        broken_status = brk;
        #1;
        chk("rotate_target", int'(station_random), 1 << ((c + 2) % 4));
        step(1'b0, 1'b0, brk, f);

        run_to_fire("all_broken");
        broken_status = 4'hF;
        #1;
        chk("all_broken_strobe", int'(station_random), 0);
        chk("all_broken_hex", int'(random_hex), m_hex);
        step(1'b0, 1'b0, 4'hF, f);
        chk("all_broken_count", int'(q_HG_Count), 1);

        run_to_fire("gameover_fire");
        step(1'b0, 1'b1, 4'h0, f);
        chk("gameover_fire_idle", int'(q_HG_Idle), 1);
        chk("gameover_fire_level", int'(hazard_level), 0);
        chk("gameover_fire_hex", int'(random_hex), 0);

        first_fire("restart_fire");

        fires = 1; cyc = 0; spacing = 0; jit = 0;
        while (fires < 38 && cyc < 6000) begin
            brk = (fires < 32 && $urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            was_count = q_HG_Count;
            step(1'b0, 1'b0, brk, f);
            cyc++;
            if (fires >= 36 && was_count) spacing++;
            if (f >= 0) begin
                fires++;
                if (fires == 4)  chk("level_after_4", int'(hazard_level), 1);
                if (fires == 32) chk("level_saturated", int'(hazard_level), 7);
                if (fires == 36) begin
                    jit = g_jit;
                    spacing = 0;
                end
                if (fires == 37) chk("min_interval_spacing", spacing, 9 + jit);
            end
        end
        if (fires < 38) chk("ramp_timeout", fires, 38);

        run_to_fire("async_reset");
        broken_status = 4'h0;
        #1;
        chk("pre_reset_strobe", int'(station_random != 4'h0), 1);
        Reset = 1'b1;
        #1;
        chk("async_reset_strobe", int'(station_random), 0);
        chk("async_reset_idle", int'(q_HG_Idle), 1);
        @(negedge timer_clk);
        Reset = 1'b0;
        model_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
